// File: rtl/fp_add_pipe.sv
// fp_add_pipe: parametrised 3-stage FP adder/subtractor (align, add, normalise/round).
// Define FP_ADD_STICKY_FLAGS_EN to build the sticky flag accumulator.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk_n,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  input  logic         flag_clr,
  output logic [3:0]   flag_sticky
);
  localparam int XW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam int NW = EXP_W + $clog2(XW + 1) + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en = !out_valid || out_ready;
  assign in_ready = en;

  logic             sgnA, sgnB;
  logic             nanA, nanB, infA, infB;
  logic             swap, bigSgn, smallSgn;
  logic [EXP_W-1:0] expA, expB, bigExp, smallExp, diff;
  logic [MAN_W-1:0] manA, manB;
  logic [XW-1:0]    extA, extB, bigMan, smallExt;
  logic [XW-1:0]    shifted, lostMask, smallMan;
  logic             special, specInv;
  logic [W-1:0]     specRes;
  int               shAmt;

  always_comb begin
    sgnA = a[W-1];
    sgnB = b[W-1] ^ sub;
    expA = a[W-2:MAN_W];
    expB = b[W-2:MAN_W];
    manA = a[MAN_W-1:0];
    manB = b[MAN_W-1:0];
    nanA = (&expA) && (|manA);
    nanB = (&expB) && (|manB);
    infA = (&expA) && !(|manA);
    infB = (&expB) && !(|manB);
    // exp==0 is flushed to zero, so no hidden bit there
    extA = (expA != '0) ? {1'b1, manA, 3'b000} : '0;
    extB = (expB != '0) ? {1'b1, manB, 3'b000} : '0;
    swap = b[W-2:0] > a[W-2:0];
    bigSgn   = swap ? sgnB : sgnA;
    smallSgn = swap ? sgnA : sgnB;
    bigExp   = swap ? expB : expA;
    smallExp = swap ? expA : expB;
    bigMan   = swap ? extB : extA;
    smallExt = swap ? extA : extB;
    diff = bigExp - smallExp;
    shAmt = (int'(diff) > MAN_W + 3) ? MAN_W + 3 : int'(diff);
    shifted = smallExt >> shAmt;
    lostMask = ~({XW{1'b1}} << shAmt);
    smallMan = {shifted[XW-1:1],
                shifted[0] | (|(smallExt & lostMask))};
    specInv = nanA || nanB || (infA && infB && (sgnA ^ sgnB));
    special = specInv || infA || infB;
    if (specInv)
      specRes = QNAN;
    else if (infA)
      specRes = {sgnA, EXP_ONES, {MAN_W{1'b0}}};
    else
      specRes = {sgnB, EXP_ONES, {MAN_W{1'b0}}};
  end

  logic             s1Valid, s1Special, s1SpecInv;
  logic [W-1:0]     s1SpecRes;
  logic             s1Sign, s1EffSub, s1BothNeg;
  logic [EXP_W-1:0] s1Exp;
  logic [XW-1:0]    s1Big, s1Small;

  always_ff @(posedge clk_n) begin
    if (rst_n) begin
      s1Valid <= 1'b0;
    end else if (en) begin
      s1Valid   <= in_valid;
      s1Special <= special;
      s1SpecInv <= specInv;
      s1SpecRes <= specRes;
      s1Sign    <= bigSgn;
      s1EffSub  <= bigSgn ^ smallSgn;
      s1BothNeg <= sgnA && sgnB;
      s1Exp     <= bigExp;
      s1Big     <= bigMan;
      s1Small   <= smallMan;
    end
  end

  logic [SW-1:0] sum;
  always_comb begin
    if (s1EffSub)
      sum = {1'b0, s1Big} - {1'b0, s1Small};
    else
      sum = {1'b0, s1Big} + {1'b0, s1Small};
  end

  logic             s2Valid, s2Special, s2SpecInv;
  logic [W-1:0]     s2SpecRes;
  logic             s2Sign, s2BothNeg;
  logic [EXP_W-1:0] s2Exp;
  logic [SW-1:0]    s2Sum;

  always_ff @(posedge clk_n) begin
    if (rst_n) begin
      s2Valid <= 1'b0;
    end else if (en) begin
      s2Valid   <= s1Valid;
      s2Special <= s1Special;
      s2SpecInv <= s1SpecInv;
      s2SpecRes <= s1SpecRes;
      s2Sign    <= s1Sign;
      s2BothNeg <= s1BothNeg;
      s2Exp     <= s1Exp;
      s2Sum     <= sum;
    end
  end

  int               lzc;
  logic [XW-1:0]    norm;
  logic [NW-1:0]    expN, expR;
  logic             g, r, st, rndUp, rCarry;
  logic [MAN_W+1:0] manR;
  logic [MAN_W-1:0] manOut;
  logic [W-1:0]     resN;
  logic [3:0]       flgN;

  always_comb begin
    lzc = 0;
    for (int i = 0; i < XW; i++)
      if (s2Sum[i]) lzc = XW - 1 - i;
    if (s2Sum[SW-1]) begin
      norm = {s2Sum[SW-1:2], |s2Sum[1:0]};
      expN = NW'(s2Exp) + NW'(1);
    end else begin
      norm = s2Sum[XW-1:0] << lzc;
      expN = NW'(s2Exp) - NW'(lzc);
    end
    g  = norm[2];
    r  = norm[1];
    st = norm[0];
    rndUp  = g && (r || st || norm[3]);
    manR   = {1'b0, norm[XW-1:3]} + (MAN_W+2)'(rndUp);
    rCarry = manR[MAN_W+1];
    manOut = rCarry ? manR[MAN_W:1] : manR[MAN_W-1:0];
    expR   = expN + NW'(rCarry);
    resN = {s2Sign, expR[EXP_W-1:0], manOut};
    flgN = {3'b000, g | r | st};
    if (s2Special) begin
      resN = s2SpecRes;
      flgN = {s2SpecInv, 3'b000};
    end else if (s2Sum == '0) begin
      resN = {s2BothNeg, {(W-1){1'b0}}};
      flgN = 4'b0000;
    end else if (expN[NW-1] || expN == '0) begin
      resN = {s2Sign, {(W-1){1'b0}}};
      flgN = 4'b0011;
    end else if (expR >= NW'(EXP_ONES)) begin
      resN = {s2Sign, EXP_ONES, {MAN_W{1'b0}}};
      flgN = 4'b0101;
    end
  end

  always_ff @(posedge clk_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= s2Valid;
      result    <= resN;
      flags     <= flgN;
    end
  end

`ifdef FP_ADD_STICKY_FLAGS_EN
  always_ff @(posedge clk_n) begin
    if (rst_n)
      flag_sticky <= '0;
    else if (flag_clr)
      flag_sticky <= '0;
    else if (out_valid && out_ready)
      flag_sticky <= flag_sticky | flags;
  end
`else
  logic unusedClr;
  assign unusedClr = flag_clr;
  assign flag_sticky = '0;
`endif

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed FP32 vectors for fp_add_pipe.
// Covers latency, rounding, specials, back-pressure, reset and sticky flags.
module tb_fp_add_pipe;
  logic        clk_n;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        flag_clr;
  logic [3:0]  flag_sticky;

  int checks = 0;
  int failures = 0;

  fp_add_pipe dut (
    .clk_n(clk_n),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags),
    .flag_clr(flag_clr),
    .flag_sticky(flag_sticky)
  );

  initial clk_n = 1'b0;
  always #5 clk_n = ~clk_n;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] av,
                       input logic [31:0] bv, input logic sv,
                       input logic [31:0] expRes, input logic [3:0] expFlg);
    int lat;
    bit seen;
    @(negedge clk_n);
    in_valid = 1'b1;
    a = av;
    b = bv;
    sub = sv;
    #1;
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    @(posedge clk_n);
    #1;
    in_valid = 1'b0;
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk_n);
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk_n);
        lat++;
      end
    end
    check({tag, ".seen"}, 32'(seen), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'd3);
    check({tag, ".res"}, result, expRes);
    check({tag, ".flg"}, 32'(flags), 32'(expFlg));
  endtask

  logic [31:0] opA [5];
  logic [31:0] opB [5];
  logic        opS [5];
  logic [31:0] opX [5];
  logic [31:0] outQ [$];
  int          acc;
  int          cyc;
  int          seenOv;
  logic        ir;

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b1;
    flag_clr = 1'b0;
    opA = '{32'h3F800000, 32'h3F800000, 32'h40000000,
            32'h40800000, 32'h3F800000};
    opB = '{32'h3F800000, 32'h40000000, 32'h40000000,
            32'h3F800000, 32'h40000000};
    opS = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opX = '{32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'hBF800000};

    repeat (3) @(posedge clk_n);
    @(negedge clk_n);
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.res", result, 32'h0);
    check("rst.flg", 32'(flags), 32'h0);
    check("rst.sticky", 32'(flag_sticky), 32'h0);
    rst_n = 1'b0;
    @(negedge clk_n);
    check("rst.ready", 32'(in_ready), 32'd1);

    runOp("add12", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    runOp("sub11", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    runOp("negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    runOp("mixz", 32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000);
    runOp("rne0", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    runOp("rne1", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
    runOp("far", 32'h3F800000, 32'h30000000, 1'b0, 32'h3F800000, 4'b0001);
    runOp("infclash", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    runOp("nan", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
    runOp("subinf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
    runOp("unf", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);

    @(negedge clk_n);
    flag_clr = 1'b1;
    @(negedge clk_n);
    flag_clr = 1'b0;
    check("sticky.clr0", 32'(flag_sticky), 32'h0);
    runOp("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    runOp("add12b", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
    @(negedge clk_n);
`ifdef FP_ADD_STICKY_FLAGS_EN
    check("sticky.acc", 32'(flag_sticky), 32'h5);
`else
    check("sticky.off", 32'(flag_sticky), 32'h0);
`endif
    flag_clr = 1'b1;
    @(negedge clk_n);
    flag_clr = 1'b0;
    check("sticky.clr1", 32'(flag_sticky), 32'h0);

    out_ready = 1'b0;
    acc = 0;
    repeat (6) begin
      @(negedge clk_n);
      in_valid = (acc < 5);
      if (acc < 5) begin
        a = opA[acc];
        b = opB[acc];
        sub = opS[acc];
      end
      #1;
      ir = in_ready;
      @(posedge clk_n);
      if (ir && in_valid) acc++;
    end
    @(negedge clk_n);
    check("bp.accepts", 32'(acc), 32'd3);
    check("bp.ready", 32'(in_ready), 32'd0);
    check("bp.ov", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cyc = 0;
    while (outQ.size() < 5 && cyc < 30) begin
      in_valid = (acc < 5);
      if (acc < 5) begin
        a = opA[acc];
        b = opB[acc];
        sub = opS[acc];
      end
      #1;
      ir = in_ready;
      if (out_valid) outQ.push_back(result);
      @(posedge clk_n);
      if (ir && in_valid) acc++;
      @(negedge clk_n);
      cyc++;
    end
    in_valid = 1'b0;
    check("bp.total", 32'(outQ.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < outQ.size())
        check($sformatf("bp.res%0d", i), outQ[i], opX[i]);
    #1;
    check("bp.drain", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    @(negedge clk_n);
    in_valid = 1'b1;
    a = opA[1];
    b = opB[1];
    sub = opS[1];
    repeat (3) @(posedge clk_n);
    @(negedge clk_n);
    in_valid = 1'b0;
    check("mid.ov", 32'(out_valid), 32'd1);
    rst_n = 1'b1;
    @(negedge clk_n);
    check("mid.rstov", 32'(out_valid), 32'd0);
    check("mid.rstres", result, 32'h0);
    rst_n = 1'b0;
    out_ready = 1'b1;
    seenOv = 0;
    repeat (5) begin
      @(negedge clk_n);
      if (out_valid) seenOv++;
    end
    check("mid.flushed", 32'(seenOv), 32'd0);
    check("mid.ready", 32'(in_ready), 32'd1);
    check("end.sticky", 32'(flag_sticky), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised IEEE-754-style floating-point adder/subtractor with configurable exponent and mantissa widths.
- 3-stage pipeline: align, add, normalise/round. Valid/ready handshake on both sides, full back-pressure.
- Round-to-nearest-even, special-value handling and status flags.
- Next-generation replacement for the fixed FP32 two-stage adder in the MAC datapath.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored mantissa field width (≥2).
- Derived, not overridable: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk_n  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- sub  in  1  1: compute a-b (b sign inverted at stage 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum/difference.
- flags  out  4  {invalid, overflow, underflow, inexact} for the current result.
- flag_clr  in  1  clear sticky flags (see Optional Feature).
- flag_sticky  out  4  accumulated flags (see Optional Feature).

Behaviour:
- Reset: all stage valid bits, out_valid, result, flags and flag_sticky go to 0. Reset during operation discards all in-flight data; in_ready is 1 from the first cycle after reset.
- Pipeline enable: en = !out_valid | out_ready. in_ready = en. A transfer occurs on in_valid & in_ready. When en=0 every stage holds its contents.
- Latency: exactly 3 cycles from accept to out_valid with no stall. Throughput is 1 result per cycle. Results emerge in issue order.
- Stage 1 (align):
  - Apply sub to b sign.
  - Compare {exp,man} magnitudes; select big/small.
  - Restore hidden 1 (exp==0 → operand treated as ±0, subnormals flushed).
  - Shift small mantissa right by the exponent difference into MAN_W+4 bits {1,man,G,R,S}; shifted-out bits OR into S. A difference ≥ MAN_W+3 leaves only S.
- Stage 2 (add): same effective sign → add, otherwise subtract small from big (never negative). Result sign = big sign. Carry-out kept.
- Stage 3 (normalise/round):
  - Carry → shift right 1, exp+1.
  - Else left-shift by leading-zero count, exp−lzc.
  - RNE on G/R/S: round up if G & (R|S|lsb). A rounding carry re-normalises, exp+1.
- Special cases, checked in stage 1 and carried down the pipe:
  - Any NaN input (exp all-ones, man≠0) → qNaN {0, all-ones exp, 1 followed by zeros}, invalid=1.
  - +inf + −inf (effective) → qNaN, invalid=1.
  - One inf → that inf, no flags.
  - Exact zero result → +0, except (−0)+(−0) → −0.
- Overflow: rounded exp ≥ all-ones → ±inf, overflow=1, inexact=1.
- Underflow: normalised exp ≤ 0 → ±0 (sign kept), underflow=1, inexact=1.
- inexact = G|R|S before rounding, for normal results.
- flags are valid only while out_valid=1 and are held with result during a stall.

Optional Feature:
- Macro: FP_ADD_STICKY_FLAGS_EN.
- Defined: flag_sticky |= flags on each output transfer (out_valid & out_ready). flag_clr=1 sets flag_sticky to 0 next cycle; it takes priority over an OR in the same cycle. flag_sticky resets to 0.
- Undefined: flag_sticky is constant 0, flag_clr is ignored, and no sticky register is synthesised.

Test Plan:
- FP32 defaults: a=0x3F800000, b=0x40000000, sub=0, out_ready=1 → result 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
- a=0x3F800000, b=0x3F800000, sub=1 → 0x00000000. a=0x80000000, b=0x80000000, sub=0 → 0x80000000.
- RNE ties: 0x3F800000+0x33800000 → 0x3F800000 with inexact=1. 0x3F800001+0x33800000 → 0x3F800002 with inexact=1.
- Specials: 0x7F800000+0xFF800000 → 0x7FC00000 with invalid=1. 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000 with overflow|inexact.
- Back-pressure: out_ready=0, stream 5 operations with in_valid=1 → in_ready drops after 3 accepts. Raise out_ready → all results appear in order, none lost or duplicated. Assert rst_n mid-stream → out_valid=0 next cycle.
- With FP_ADD_STICKY_FLAGS_EN: run the overflow case then 1.0+2.0 → flag_sticky=0b0101. Pulse flag_clr → 0. Without the macro, flag_sticky stays 0 throughout.
